// File: rtl/mem_pkg.sv
// Shared constants for the fetch/load-store memory slice: default geometry,
// arbitration threshold, decoder opcode field widths and the initial image.
package mem_pkg;

   localparam int DEF_DATA_W     = 16;
   localparam int DEF_ADDR_W     = 9;
   localparam int DEF_DEPTH      = 512;
   localparam int DEF_STARVE_MAX = 4;

   // Instruction field widths, shared with the decoder.
   localparam int OPCODE_W = 7;
   localparam int FUNCT3_W = 3;
   localparam int FUNCT7_W = 7;

   // Initial memory image: a simple address-dependent pattern, so that every
   // word is distinct and easy to predict.
   function automatic logic [31:0] mem_init_word(input int unsigned idx);
      return (idx * 32'd37) ^ 32'h0000_5A3C;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port synchronous RAM: one access per cycle, read data registered
// (1-cycle latency), write on the edge that ends the access cycle. Contents
// are preloaded at elaboration and are never cleared by reset.
module mem_array
   import mem_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              ck,
   input  logic              en,
   input  logic              we,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   typedef logic [DATA_W-1:0] image_t [DEPTH];

   function automatic image_t build_image();
      image_t img;
      for (int i = 0; i < DEPTH; i++) begin
         img[i] = DATA_W'(mem_init_word(i));
      end
      return img;
   endfunction

   image_t            mem_q = build_image();
   logic [DATA_W-1:0] rdata_q;

   // One access per cycle; the caller only enables in-range addresses.
   always_ff @(posedge ck) begin
      if (en) begin
         if (we) begin
            mem_q[addr] <= wdata;
         end else begin
            rdata_q <= mem_q[addr];
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fetch_lsu_mem.sv
// Shared instruction/data memory front end. Load/store has priority, but a
// fetch that has been denied STARVE_MAX consecutive cycles is forced through.
// Responses arrive one cycle after the grant; out-of-range load/store is
// granted, never writes, returns zero data and raises ls_err.
// Handshake: a request is accepted in the cycle its gnt is high; nothing is
// queued, so the requester holds req/addr/data until it sees gnt. The
// response (rvalid, rdata, err) is a one-cycle pulse in the next cycle.
module fetch_lsu_mem
   import mem_pkg::*;
#(
   parameter int DATA_W     = DEF_DATA_W,
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int DEPTH      = DEF_DEPTH,    // must not exceed 2**ADDR_W
   parameter int STARVE_MAX = DEF_STARVE_MAX
) (
   input  logic              ck,
   input  logic              rst_n,
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   output logic              if_gnt,
   output logic              if_rvalid,
   output logic [DATA_W-1:0] if_rdata,
   input  logic              ls_req,
   input  logic              ls_we,
   input  logic [ADDR_W-1:0] ls_addr,
   input  logic [DATA_W-1:0] ls_wdata,
   output logic              ls_gnt,
   output logic              ls_rvalid,
   output logic [DATA_W-1:0] ls_rdata,
   output logic              ls_err
);

   localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);
   localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);

   logic [CNT_W-1:0]  starve_q, starve_d;
   logic              starve_hit;
   logic              if_gnt_c, ls_gnt_c;
   logic [ADDR_W-1:0] mem_addr;
   logic              addr_ok;
   logic              mem_en, mem_we;
   logic [DATA_W-1:0] mem_rdata;
   logic [DATA_W-1:0] resp_data;

   logic              if_rv_q, ls_rv_q, ls_err_q, oor_q;
   logic [DATA_W-1:0] if_hold_q, ls_hold_q;

   // Arbitration: load/store wins unless fetch has starved; nothing is
   // granted while reset is asserted.
   always_comb begin
      starve_hit = (starve_q == CNT_MAX);
      if_gnt_c   = rst_n & if_req & (~ls_req | starve_hit);
      ls_gnt_c   = rst_n & ls_req & ~if_gnt_c;
      mem_addr   = if_gnt_c ? if_addr : ls_addr;
      addr_ok    = ({1'b0, mem_addr} < DEPTH_L);
      mem_en     = (if_gnt_c | ls_gnt_c) & addr_ok;
      mem_we     = ls_gnt_c & ls_we;
   end

   // Starvation counter: counts consecutive denied fetch cycles, saturating.
   always_comb begin
      starve_d = starve_q;
      if (if_gnt_c || !if_req) begin
         starve_d = '0;
      end else if (!starve_hit) begin
         starve_d = starve_q + CNT_W'(1);
      end
   end

   mem_array #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .ck    (ck),
      .en    (mem_en),
      .we    (mem_we),
      .addr  (mem_addr),
      .wdata (ls_wdata),
      .rdata (mem_rdata)
   );

   // Only one access is outstanding at a time, so one out-of-range flag serves
   // whichever port owns the response.
   assign resp_data = oor_q ? '0 : mem_rdata;

   // Response tracking and per-port hold registers for the returned data.
   always_ff @(posedge ck) begin
      if (!rst_n) begin
         starve_q  <= '0;
         if_rv_q   <= 1'b0;
         ls_rv_q   <= 1'b0;
         ls_err_q  <= 1'b0;
         oor_q     <= 1'b0;
         if_hold_q <= '0;
         ls_hold_q <= '0;
      end else begin
         starve_q <= starve_d;
         if_rv_q  <= if_gnt_c;
         ls_rv_q  <= ls_gnt_c & ~ls_we;
         ls_err_q <= ls_gnt_c & ~addr_ok;
         oor_q    <= ~addr_ok;
         if (if_rv_q) begin
            if_hold_q <= resp_data;
         end
         if (ls_rv_q) begin
            ls_hold_q <= resp_data;
         end
      end
   end

   // Outputs are forced low while reset is held, including a response that
   // was already in flight when reset arrived.
   always_comb begin
      if_gnt    = if_gnt_c;
      ls_gnt    = ls_gnt_c;
      if_rvalid = rst_n & if_rv_q;
      ls_rvalid = rst_n & ls_rv_q;
      ls_err    = rst_n & ls_err_q;
      if_rdata  = '0;
      ls_rdata  = '0;
      if (rst_n) begin
         if_rdata = if_rv_q ? resp_data : if_hold_q;
         ls_rdata = ls_rv_q ? resp_data : ls_hold_q;
      end
   end

endmodule

// File: tb/tb_fetch_lsu_mem.sv
// Bench for fetch_lsu_mem: directed scenarios followed by randomized traffic,
// all checked against a behavioural model of the shared memory.
module tb_fetch_lsu_mem;

   localparam int DATA_W     = 16;
   localparam int ADDR_W     = 9;
   localparam int DEPTH      = 300;
   localparam int STARVE_MAX = 4;
   localparam int RAND_CYC   = 600;

   logic              ck = 1'b0;
   logic              rst_n = 1'b0;
   logic              if_req = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_gnt, if_rvalid;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req = 1'b0;
   logic              ls_we = 1'b0;
   logic [ADDR_W-1:0] ls_addr = '0;
   logic [DATA_W-1:0] ls_wdata = '0;
   logic              ls_gnt, ls_rvalid, ls_err;
   logic [DATA_W-1:0] ls_rdata;

   int n_checks = 0;
   int n_fail   = 0;

   // reference model state
   logic [DATA_W-1:0] m_mem [1 << ADDR_W];
   int                m_denied;
   bit                p_if, p_ls, p_err;
   logic [DATA_W-1:0] p_if_d, p_ls_d, h_if, h_ls;
   bit                last_if_gnt, last_ls_gnt;

   fetch_lsu_mem #(
      .DATA_W     (DATA_W),
      .ADDR_W     (ADDR_W),
      .DEPTH      (DEPTH),
      .STARVE_MAX (STARVE_MAX)
   ) dut (
      .ck        (ck),
      .rst_n     (rst_n),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .ls_err    (ls_err)
   );

   // clock
   always #5 ck = ~ck;

   function automatic logic [DATA_W-1:0] image_word(input int idx);
      int unsigned v;
      v = (idx * 37) ^ 'h5A3C;
      return v[DATA_W-1:0];
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Behavioural model of one cycle, evaluated at the falling edge with the
   // cycle's inputs stable: compare outputs, then advance the model.
   task automatic model_cycle();
      bit                eg_if, eg_ls;
      logic [DATA_W-1:0] ex_if_d, ex_ls_d;
      if (!rst_n) begin
         check_eq("rst_if_gnt", if_gnt, 0);
         check_eq("rst_ls_gnt", ls_gnt, 0);
         check_eq("rst_if_rvalid", if_rvalid, 0);
         check_eq("rst_ls_rvalid", ls_rvalid, 0);
         check_eq("rst_ls_err", ls_err, 0);
         check_eq("rst_if_rdata", if_rdata, 0);
         check_eq("rst_ls_rdata", ls_rdata, 0);
         p_if = 0; p_ls = 0; p_err = 0;
         h_if = '0; h_ls = '0;
         m_denied = 0;
         last_if_gnt = 0; last_ls_gnt = 0;
         return;
      end
      eg_if = if_req && (!ls_req || m_denied == STARVE_MAX);
      eg_ls = ls_req && !eg_if;
      ex_if_d = p_if ? p_if_d : h_if;
      ex_ls_d = p_ls ? p_ls_d : h_ls;
      check_eq("if_gnt", if_gnt, eg_if);
      check_eq("ls_gnt", ls_gnt, eg_ls);
      check_eq("if_rvalid", if_rvalid, p_if);
      check_eq("ls_rvalid", ls_rvalid, p_ls);
      check_eq("ls_err", ls_err, p_err);
      check_eq("if_rdata", if_rdata, ex_if_d);
      check_eq("ls_rdata", ls_rdata, ex_ls_d);
      h_if = ex_if_d;
      h_ls = ex_ls_d;
      p_if = eg_if;
      if (eg_if) p_if_d = (if_addr < DEPTH) ? m_mem[if_addr] : '0;
      p_ls  = eg_ls && !ls_we;
      p_err = eg_ls && (ls_addr >= DEPTH);
      if (eg_ls && !ls_we) p_ls_d = (ls_addr < DEPTH) ? m_mem[ls_addr] : '0;
      if (eg_ls && ls_we && ls_addr < DEPTH) m_mem[ls_addr] = ls_wdata;
      if (!if_req || eg_if) m_denied = 0;
      else if (m_denied < STARVE_MAX) m_denied++;
      last_if_gnt = eg_if;
      last_ls_gnt = eg_ls;
   endtask

   // driver: one clock cycle; returns 1 time unit after the next rising edge
   task automatic step();
      @(negedge ck);
      model_cycle();
      @(posedge ck);
      #1;
   endtask

   function automatic logic [ADDR_W-1:0] rand_addr();
      if ($urandom_range(0, 3) == 0) return ADDR_W'($urandom_range(0, (1 << ADDR_W) - 1));
      return ADDR_W'($urandom_range(0, 15));
   endfunction

   initial begin
      for (int i = 0; i < (1 << ADDR_W); i++) m_mem[i] = image_word(i);
      m_denied = 0; p_if = 0; p_ls = 0; p_err = 0;
      p_if_d = '0; p_ls_d = '0; h_if = '0; h_ls = '0;

      // reset
      step();
      step();
      rst_n = 1'b1;

      // single fetch from address 0
      if_req = 1; if_addr = '0;
      #1 check_eq("fetch0_gnt", if_gnt, 1);
      step();
      if_req = 0;
      check_eq("fetch0_rvalid", if_rvalid, 1);
      check_eq("fetch0_rdata", if_rdata, image_word(0));

      // store then immediate load of the same address
      ls_req = 1; ls_we = 1; ls_addr = 10; ls_wdata = 16'hABCD;
      step();
      ls_we = 0;
      step();
      ls_req = 0;
      check_eq("raw_rvalid", ls_rvalid, 1);
      check_eq("raw_rdata", ls_rdata, 16'hABCD);

      // contention: fetch forced through after STARVE_MAX denials
      if_req = 1; if_addr = 3; ls_req = 1; ls_we = 0; ls_addr = 5;
      for (int i = 0; i < 7; i++) begin
         #1;
         check_eq("starve_if_gnt", if_gnt, (i == STARVE_MAX));
         check_eq("starve_ls_gnt", ls_gnt, (i != STARVE_MAX));
         step();
      end
      if_req = 0; ls_req = 0;
      step();

      // out-of-range load and store
      ls_req = 1; ls_we = 0; ls_addr = 400;
      step();
      check_eq("oor_ld_rvalid", ls_rvalid, 1);
      check_eq("oor_ld_rdata", ls_rdata, 0);
      check_eq("oor_ld_err", ls_err, 1);
      ls_we = 1; ls_wdata = 16'h1234;
      step();
      check_eq("oor_st_err", ls_err, 1);
      check_eq("oor_st_rvalid", ls_rvalid, 0);
      ls_we = 0; ls_addr = 144;   // 400 with the top bit dropped
      step();
      ls_req = 0;
      check_eq("oor_no_alias", ls_rdata, image_word(144));

      // load granted, then reset for one cycle
      ls_req = 1; ls_we = 0; ls_addr = 7;
      step();
      ls_req = 0; rst_n = 0;
      step();
      rst_n = 1;
      #1;
      check_eq("rst_drop_rvalid", ls_rvalid, 0);
      check_eq("rst_drop_rdata", ls_rdata, 0);
      if_req = 1; if_addr = '0;
      step();
      if_req = 0;
      check_eq("post_rst_mem0", if_rdata, image_word(0));

      // randomized traffic; requesters hold until granted
      for (int c = 0; c < RAND_CYC; c++) begin
         rst_n = ($urandom_range(0, 99) != 0);
         if (!(if_req && !last_if_gnt)) begin
            if_req  = ($urandom_range(0, 2) != 0);
            if_addr = rand_addr();
         end
         if (!(ls_req && !last_ls_gnt)) begin
            ls_req   = ($urandom_range(0, 2) != 0);
            ls_we    = $urandom_range(0, 1);
            ls_addr  = rand_addr();
            ls_wdata = DATA_W'($urandom);
         end
         step();
      end
      rst_n = 1; if_req = 0; ls_req = 0;
      step();
      step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
